// File: rtl/btn_debouncer.sv
// Push-button debouncer: two-flop synchronizer feeding a press/release
// stability FSM with a registered one-cycle press pulse and debounced level.
module btn_debouncer #(
  parameter int DebounceWait = 40000,
  parameter int DebounceSize = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic button_pressed,
  output logic button_level
);

  typedef enum logic [2:0] {
    Reset      = 3'd0,
    Idle       = 3'd1,
    DebPress   = 3'd2,
    Held       = 3'd3,
    DebRelease = 3'd4,
    Error      = 3'd5
  } state_t;

  localparam logic [DebounceSize-1:0] Last =
    DebounceSize'(DebounceWait - 1);
  localparam logic [DebounceSize-1:0] One =
    DebounceSize'(1);

  logic                    sync0;
  logic                    sync1;
  state_t                  state;
  state_t                  state_nxt;
  logic [DebounceSize-1:0] count;
  logic [DebounceSize-1:0] count_nxt;
  logic                    pressed_nxt;
  logic                    level_nxt;
  logic                    at_last;

  // >= keeps the counter bounded even if it were ever disturbed
  assign at_last = (count >= Last);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync0          <= 1'b0;
      sync1          <= 1'b0;
      state          <= Reset;
      count          <= '0;
      button_pressed <= 1'b0;
      button_level   <= 1'b0;
    end else begin
      sync0          <= button;
      sync1          <= sync0;
      state          <= state_nxt;
      count          <= count_nxt;
      button_pressed <= pressed_nxt;
      button_level   <= level_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    pressed_nxt = 1'b0;
    level_nxt   = button_level;
    case (state)
      Reset: begin
        state_nxt = Idle;
        count_nxt = '0;
        level_nxt = 1'b0;
      end
      Idle: begin
        count_nxt = '0;
        level_nxt = 1'b0;
        if (sync1) state_nxt = DebPress;
      end
      DebPress: begin
        if (!sync1) begin
          state_nxt = Idle;
          count_nxt = '0;
        end else if (at_last) begin
          state_nxt   = Held;
          count_nxt   = '0;
          pressed_nxt = 1'b1;
          level_nxt   = 1'b1;
        end else begin
          count_nxt = count + One;
        end
      end
      Held: begin
        count_nxt = '0;
        level_nxt = 1'b1;
        if (!sync1) state_nxt = DebRelease;
      end
      DebRelease: begin
        if (sync1) begin
          state_nxt = Held;
          count_nxt = '0;
        end else if (at_last) begin
          state_nxt = Idle;
          count_nxt = '0;
          level_nxt = 1'b0;
        end else begin
          count_nxt = count + One;
        end
      end
      Error: begin
        count_nxt = '0;
        level_nxt = 1'b0;
      end
      default: begin
        state_nxt = Error;
        count_nxt = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer (DebounceWait=4, DebounceSize=3) with a
// per-cycle scoreboard of expected pulse/level values.
module tb_btn_debouncer;

  localparam int W = 4;
  localparam int S = 3;
  localparam int L = W + 2;

  logic clock = 1'b0;
  logic reset;
  logic button;
  logic button_pressed;
  logic button_level;

  btn_debouncer #(
    .DebounceWait(W),
    .DebounceSize(S)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .button        (button),
    .button_pressed(button_pressed),
    .button_level  (button_level)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic  p;
    logic  l;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty observed=%b%b required=entry",
             button_pressed, button_level);
      return;
    end
    e = sb.pop_front();
    compared++;
    assert ({button_pressed, button_level} === {e.p, e.l})
    else begin
      mismatched++;
      $error("FAIL %s: observed pressed=%b level=%b required pressed=%b level=%b",
             e.tag, button_pressed, button_level, e.p, e.l);
    end
  endtask

  task automatic step(input logic b, input logic r,
                      input logic p, input logic l,
                      input string tag);
    exp_t e;
    @(negedge clock);
    button = b;
    reset  = r;
    e.p    = p;
    e.l    = l;
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clock);
    #1;
    check_out();
  endtask

  task automatic check_bound(input string tag);
    compared++;
    assert ((dut.count <= 3'(W - 1)) === 1'b1)
    else begin
      mismatched++;
      $error("FAIL %s: observed count=%0d required <= %0d",
             tag, dut.count, W - 1);
    end
  endtask

  initial begin
    reset  = 1'b1;
    button = 1'b0;

    step(0, 1, 0, 0, "reset0");
    step(0, 1, 0, 0, "reset1");
    for (int j = 0; j < 3; j++)
      step(0, 0, 0, 0, $sformatf("idle_%0d", j));

    // clean press then clean release
    for (int j = 0; j < 20; j++)
      step(1, 0, j == L, j >= L, $sformatf("clean_press_%0d", j));
    for (int j = 0; j < 12; j++)
      step(0, 0, 0, j < L, $sformatf("clean_release_%0d", j));

    // bounce 1,0,1,0,1 then stable high
    for (int j = 0; j < 16; j++)
      step((j < 5) ? logic'(j % 2 == 0) : 1'b1, 0,
           j == 4 + L, j >= 4 + L, $sformatf("bounce_%0d", j));
    for (int j = 0; j < 10; j++)
      step(0, 0, 0, j < L, $sformatf("bounce_release_%0d", j));

    // short glitch, then a normal press proves a clean return to Idle
    for (int j = 0; j < 13; j++)
      step(j < 3, 0, 0, 0, $sformatf("glitch_%0d", j));
    for (int j = 0; j < 8; j++)
      step(1, 0, j == L, j >= L, $sformatf("glitch_recover_%0d", j));

    // release bounce from Held: 0,0,1,1,1 then low for good
    for (int j = 0; j < 16; j++)
      step((j >= 2 && j < 5), 0, 0, j < 5 + L,
           $sformatf("release_bounce_%0d", j));

    // reset while DebPress count is 2
    for (int j = 0; j < 5; j++)
      step(1, 0, 0, 0, $sformatf("mid_press_%0d", j));
    step(1, 1, 0, 0, "mid_press_reset");
    for (int j = 0; j < 12; j++)
      step(1, 0, j == L, j >= L, $sformatf("after_reset_%0d", j));
    for (int j = 0; j < 10; j++)
      step(0, 0, 0, j < L, $sformatf("after_reset_rel_%0d", j));

    // long hold with counter bound checks
    for (int j = 0; j < 100; j++) begin
      step(1, 0, j == L, j >= L, $sformatf("long_hold_%0d", j));
      check_bound($sformatf("long_hold_cnt_%0d", j));
    end

    // reset while Held, button still pressed
    step(1, 1, 0, 0, "mid_held_reset");
    for (int j = 0; j < 12; j++)
      step(1, 0, j == L, j >= L, $sformatf("after_held_reset_%0d", j));
    for (int j = 0; j < 10; j++)
      step(0, 0, 0, j < L, $sformatf("final_release_%0d", j));

    if (sb.size() != 0) begin
      mismatched++;
      $error("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
